alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU; result captured ALU_LAT+1 cycles after grant.
// No backpressure: requests are level-held, sampled only while idle; done is a one-cycle pulse.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] A0,
  input  logic [15:0] B0,
  input  logic [15:0] A1,
  input  logic [15:0] B1,
  input  logic [3:0]  fun0,
  input  logic [3:0]  fun1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] res,
  output logic        res_flag,
  output logic        res_carry,
  output logic        busy,
  output logic [15:0] op_cnt,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [3:0]  alu_fun,
  input  logic [15:0] ari_out,
  input  logic [15:0] log_out,
  input  logic [15:0] cmp_out,
  input  logic [15:0] shift_out,
  input  logic        carry_out,
  input  logic        ari_flag,
  input  logic        log_flag,
  input  logic        cmp_flag,
  input  logic        shift_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
  } op_t;

  typedef struct packed {
    logic [15:0] val;
    logic        flag;
    logic        carry;
  } res_t;

  localparam logic [2:0] LAT_LD = 3'(ALU_LAT);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_prio;
  logic        r_gnt;
  op_t         r_op;
  res_t        r_res;
  logic        r_done0;
  logic        r_done1;
  logic        r_busy;
  logic [15:0] r_op_cnt;

  op_t  w_op0;
  op_t  w_op1;
  logic w_pick1;
  res_t w_alu_res;

  assign w_op0 = {A0, B0, fun0};
  assign w_op1 = {A1, B1, fun1};

  // Contention goes to the pointer; a lone request wins outright.
  always_comb begin
    w_pick1 = 1'b0;
    if (req0 && req1) w_pick1 = r_prio;
    else              w_pick1 = req1;
  end

  always_comb begin
    w_alu_res = '0;
    case (r_op.fun[3:2])
      2'b00:   w_alu_res = {ari_out, ari_flag, carry_out};
      2'b01:   w_alu_res = {log_out, log_flag, 1'b0};
      2'b10:   w_alu_res = {cmp_out, cmp_flag, 1'b0};
      default: w_alu_res = {shift_out, shift_flag, 1'b0};
    endcase
  end

  // Counter runs ALU_LAT down to 0, so the sample lands one cycle after the ALU's own latency.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_prio   <= 1'b0;
      r_gnt    <= 1'b0;
      r_op     <= '0;
      r_res    <= '0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_busy   <= 1'b0;
      r_op_cnt <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_gnt   <= w_pick1;
            r_op    <= w_pick1 ? w_op1 : w_op0;
            r_cnt   <= LAT_LD;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (r_cnt == 3'd0) begin
            r_res   <= w_alu_res;
            r_done0 <= ~r_gnt;
            r_done1 <= r_gnt;
            if (r_op_cnt != 16'hFFFF) r_op_cnt <= r_op_cnt + 16'd1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_busy  <= 1'b0;
          r_prio  <= ~r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done0     = r_done0;
  assign done1     = r_done1;
  assign res       = r_res.val;
  assign res_flag  = r_res.flag;
  assign res_carry = r_res.carry;
  assign busy      = r_busy;
  assign op_cnt    = r_op_cnt;
  assign alu_A     = r_op.a;
  assign alu_B     = r_op.b;
  assign alu_fun   = r_op.fun;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboarded bench for alu_arbiter: one ALU_LAT=1 instance for function, one ALU_LAT=4 for reset/latency.
// Behavioural ALU model feeds both instances; expected results are hand-computed constants.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ari, lg, cmp, sh;
    logic        carry, af, lf, cf, sf;
  } alu_t;

  typedef struct packed {
    logic        who;
    logic [15:0] r;
    logic        f;
    logic        c;
    logic [15:0] n;
  } exp_t;

  function automatic alu_t alu_model(input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] f, input logic o);
    alu_t        m;
    logic [16:0] s;
    s       = {1'b0, a} + {1'b0, b};
    m.ari   = o ? 16'hFFFF : s[15:0];
    m.carry = o ? 1'b1 : s[16];
    m.af    = (m.ari == 16'h0);
    case (f[1:0])
      2'b00:   m.lg = a & b;
      2'b01:   m.lg = a | b;
      2'b10:   m.lg = a ^ b;
      default: m.lg = ~a;
    endcase
    m.lf  = (m.lg == 16'h0);
    m.cmp = o ? 16'd3 : {15'd0, (a < b)};
    m.cf  = o ? 1'b1 : (a == b);
    m.sh  = a << b[3:0];
    m.sf  = a[15];
    return m;
  endfunction

  logic        rest, req0, req1, ovr;
  logic [15:0] A0, B0, A1, B1;
  logic [3:0]  fun0, fun1;
  logic        done0, done1, res_flag, res_carry, busy;
  logic [15:0] res, op_cnt, alu_A, alu_B;
  logic [3:0]  alu_fun;
  logic [15:0] ari_out, log_out, cmp_out, shift_out;
  logic        carry_out, ari_flag, log_flag, cmp_flag, shift_flag;
  alu_t        m1;

  assign m1 = alu_model(alu_A, alu_B, alu_fun, ovr);
  assign {ari_out, log_out, cmp_out, shift_out, carry_out, ari_flag, log_flag, cmp_flag, shift_flag} = m1;

  alu_arbiter #(.ALU_LAT(1)) u_dut (
    .clk(clk), .rest(rest), .req0(req0), .req1(req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1), .fun0(fun0), .fun1(fun1),
    .done0(done0), .done1(done1), .res(res), .res_flag(res_flag), .res_carry(res_carry),
    .busy(busy), .op_cnt(op_cnt), .alu_A(alu_A), .alu_B(alu_B), .alu_fun(alu_fun),
    .ari_out(ari_out), .log_out(log_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .carry_out(carry_out), .ari_flag(ari_flag), .log_flag(log_flag),
    .cmp_flag(cmp_flag), .shift_flag(shift_flag)
  );

  logic        rest_4, req0_4, req1_4;
  logic [15:0] A0_4, B0_4, A1_4, B1_4;
  logic [3:0]  fun0_4, fun1_4;
  logic        done0_4, done1_4, res_flag_4, res_carry_4, busy_4;
  logic [15:0] res_4, op_cnt_4, alu_A_4, alu_B_4;
  logic [3:0]  alu_fun_4;
  alu_t        m4;

  assign m4 = alu_model(alu_A_4, alu_B_4, alu_fun_4, 1'b0);

  alu_arbiter #(.ALU_LAT(4)) u_dut4 (
    .clk(clk), .rest(rest_4), .req0(req0_4), .req1(req1_4),
    .A0(A0_4), .B0(B0_4), .A1(A1_4), .B1(B1_4), .fun0(fun0_4), .fun1(fun1_4),
    .done0(done0_4), .done1(done1_4), .res(res_4), .res_flag(res_flag_4), .res_carry(res_carry_4),
    .busy(busy_4), .op_cnt(op_cnt_4), .alu_A(alu_A_4), .alu_B(alu_B_4), .alu_fun(alu_fun_4),
    .ari_out(m4.ari), .log_out(m4.lg), .cmp_out(m4.cmp), .shift_out(m4.sh),
    .carry_out(m4.carry), .ari_flag(m4.af), .log_flag(m4.lf),
    .cmp_flag(m4.cf), .shift_flag(m4.sf)
  );

  int          checks   = 0;
  int          failures = 0;
  int          d4_dones = 0;
  logic [15:0] exp_cnt  = 16'd0;
  exp_t        sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic push(input logic who, input logic [15:0] r, input logic f, input logic c);
    exp_t e;
    if (exp_cnt != 16'hFFFF) exp_cnt++;
    e.who = who; e.r = r; e.f = f; e.c = c; e.n = exp_cnt;
    sbq.push_back(e);
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int n = 0;
    while (busy !== lvl && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) timeout(nm);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!(done0 | done1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(done0 | done1)) timeout(nm);
  endtask

  task automatic issue(input logic who, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, input logic o,
                       input logic [15:0] er, input logic ef, input logic ec);
    @(negedge clk);
    ovr = o;
    if (who) begin A1 = a; B1 = b; fun1 = f; req1 = 1'b1; end
    else     begin A0 = a; B0 = b; fun0 = f; req0 = 1'b1; end
    push(who, er, ef, ec);
    @(negedge clk);
    wait_busy(1'b1, "issue_grant");
    chk("issue_alu_A", alu_A, a);
    chk("issue_alu_B", alu_B, b);
    chk("issue_alu_fun", alu_fun, f);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_busy(1'b0, "issue_retire");
  endtask

  // Monitor: every completion pulse is matched against the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      chk("done_exclusive", done0 & done1, 0);
      if (done0 | done1) begin
        if (sbq.size() == 0) begin
          timeout("sb_unexpected_done");
        end else begin
          e = sbq.pop_front();
          chk("sb_who", done1, e.who);
          chk("sb_res", res, e.r);
          chk("sb_flag", res_flag, e.f);
          chk("sb_carry", res_carry, e.c);
          chk("sb_op_cnt", op_cnt, e.n);
        end
      end
    end
  end

  initial begin : monitor4
    forever begin
      @(negedge clk);
      if (done0_4 | done1_4) d4_dones++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rest = 1'b1; req0 = 1'b0; req1 = 1'b0; ovr = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0; fun0 = '0; fun1 = '0;
    rest_4 = 1'b1; req0_4 = 1'b0; req1_4 = 1'b0;
    A0_4 = '0; B0_4 = '0; A1_4 = '0; B1_4 = '0; fun0_4 = '0; fun1_4 = '0;
    repeat (2) @(negedge clk);

    chk("rst_res", res, 0);
    chk("rst_flag", res_flag, 0);
    chk("rst_carry", res_carry, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_done", {done0, done1}, 0);
    chk("rst_alu_op", {alu_A, alu_B, alu_fun}, 0);
    chk("rst_prio", u_dut.r_prio, 0);

    // Single request, ALU_LAT=1, exact latency
    rest = 1'b0; rest_4 = 1'b0;
    req0 = 1'b1; A0 = 16'd3; B0 = 16'd2; fun0 = 4'b0000;
    push(1'b0, 16'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_alu_A", alu_A, 3);
    chk("t1_alu_B", alu_B, 2);
    chk("t1_busy", busy, 1);
    req0 = 1'b0;
    @(negedge clk);
    chk("t1_done_early", done0, 0);
    @(negedge clk);
    chk("t1_done0", done0, 1);
    chk("t1_done1", done1, 0);
    @(negedge clk);
    chk("t1_pulse_width", done0, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_res_hold", res, 5);

    // Contention after reset; requests presented during reset are ignored
    @(negedge clk);
    rest = 1'b1; req0 = 1'b1; req1 = 1'b1;
    A0 = 16'd3; B0 = 16'd5; fun0 = 4'b0100;
    A1 = 16'd3; B1 = 16'd5; fun1 = 4'b0101;
    @(negedge clk);
    rest = 1'b0;
    chk("t2_rst_busy", busy, 0);
    chk("t2_rst_op_cnt", op_cnt, 0);
    chk("t2_rst_res", res, 0);
    exp_cnt = 16'd0;
    push(1'b0, 16'd1, 1'b0, 1'b0);
    push(1'b1, 16'd7, 1'b0, 1'b0);
    push(1'b0, 16'd1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_done("t2_done");
      if (k < 2) begin
        @(negedge clk);
        chk("t2_gap_idle", busy, 0);
        @(negedge clk);
        chk("t2_gap_regrant", busy, 1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_busy(1'b0, "t2_retire");

    // Result mux and carry masking
    issue(1'b1, 16'h0000, 16'h0000, 4'b1011, 1'b1, 16'h0003, 1'b1, 1'b0);
    issue(1'b1, 16'hFFF1, 16'h0014, 4'b1100, 1'b0, 16'hFF10, 1'b1, 1'b0);
    issue(1'b0, 16'hFFFF, 16'h0002, 4'b0000, 1'b0, 16'h0001, 1'b0, 1'b1);
    issue(1'b0, 16'h00F0, 16'h0000, 4'b0111, 1'b0, 16'hFF0F, 1'b0, 1'b0);
    chk("t3_prio", u_dut.r_prio, 1);

    // Saturation from a preloaded count
    @(negedge clk);
    force u_dut.r_op_cnt = 16'hFFFD;
    @(negedge clk);
    release u_dut.r_op_cnt;
    exp_cnt = 16'hFFFD;
    chk("t4_preload", op_cnt, 16'hFFFD);
    issue(1'b0, 16'h0001, 16'h0001, 4'b0000, 1'b0, 16'h0002, 1'b0, 1'b0);
    issue(1'b1, 16'h0003, 16'h0005, 4'b0110, 1'b0, 16'h0006, 1'b0, 1'b0);
    issue(1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t4_saturated", op_cnt, 16'hFFFF);

    // ALU_LAT=4: reset during the second EXEC cycle abandons the operation
    @(negedge clk);
    req0_4 = 1'b1; A0_4 = 16'd1; B0_4 = 16'd1; fun0_4 = 4'b0000;
    @(negedge clk);
    req0_4 = 1'b0;
    chk("t5_grant", busy_4, 1);
    @(negedge clk);
    rest_4 = 1'b1;
    @(negedge clk);
    rest_4 = 1'b0;
    chk("t5_rst_busy", busy_4, 0);
    chk("t5_rst_op_cnt", op_cnt_4, 0);
    chk("t5_rst_prio", u_dut4.r_prio, 0);
    repeat (8) @(negedge clk);
    chk("t5_no_done", d4_dones, 0);
    req1_4 = 1'b1; A1_4 = 16'd2; B1_4 = 16'd3; fun1_4 = 4'b0000;
    @(negedge clk);
    req1_4 = 1'b0;
    chk("t5_alu_A", alu_A_4, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_done_early", done1_4, 0);
    end
    @(negedge clk);
    chk("t5_done1", done1_4, 1);
    chk("t5_done0", done0_4, 0);
    chk("t5_res", res_4, 5);
    chk("t5_op_cnt", op_cnt_4, 1);
    @(negedge clk);
    chk("t5_total_dones", d4_dones, 1);

    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
